// File: rtl/bias_stream_pp_pkg.sv
// rtl/bias_stream_pp_pkg.sv - shared widths and fill-state encoding for the bias feeder
package bias_stream_pp_pkg;

  localparam int BIAS_W = 16;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2
  } fill_state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bias_stream_pp_if.sv
// rtl/bias_stream_pp_if.sv - bias BRAM read port and consumer-side bias handshake
interface bias_stream_pp_if
  import bias_stream_pp_pkg::*;
#(
  parameter int BIAS_W = bias_stream_pp_pkg::BIAS_W,
  parameter int LANES  = bias_stream_pp_pkg::LANES
);

  logic                      src_avail;
  logic                      src_rd_en;
  logic [LANES*BIAS_W-1:0]   src_din;
  logic                      conv_end;
  logic [BIAS_W-1:0]         bias_data;
  logic                      bias_valid;

  // master is the feeder; slave is the BRAM plus consumer side.
  modport master (
    input  src_avail, src_din, conv_end,
    output src_rd_en, bias_data, bias_valid
  );

  modport slave (
    output src_avail, src_din, conv_end,
    input  src_rd_en, bias_data, bias_valid
  );

endinterface

// File: rtl/bias_stream_pp_bank_rf.sv
// rtl/bias_stream_pp_bank_rf.sv - NBUF-deep packed-word bank file with full flags and lane mux
module bias_stream_pp_bank_rf
  import bias_stream_pp_pkg::*;
#(
  parameter int BIAS_W = bias_stream_pp_pkg::BIAS_W,
  parameter int LANES  = bias_stream_pp_pkg::LANES,
  parameter int NBUF   = 2,
  parameter int LANE_W = idx_w(LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    wr_en_i,
  input  logic [LANES*BIAS_W-1:0] wr_data_i,
  input  logic                    free_i,
  input  logic [LANE_W-1:0]       lane_idx_i,
  output logic                    wr_full_o,
  output logic                    rd_full_o,
  output logic [BIAS_W-1:0]       rd_lane_o
);

  localparam int PTR_W = idx_w(NBUF);

  logic [LANES*BIAS_W-1:0] mem_q [NBUF];
  logic [NBUF-1:0]         full_q;
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;

  // Occupancy and ring pointers; a clear wins over a fill or free in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      full_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) begin
        full_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (free_i) begin
        full_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Word storage; contents are only meaningful while the matching full flag is set.
  always_ff @(posedge clk) begin
    if (wr_en_i && !clr_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign wr_full_o = full_q[wr_ptr_q];
  assign rd_full_o = full_q[rd_ptr_q];
  assign rd_lane_o = mem_q[rd_ptr_q][int'(lane_idx_i)*BIAS_W +: BIAS_W];

endmodule

// File: rtl/bias_stream_pp.sv
// rtl/bias_stream_pp.sv - ping-pong bias feeder: fetch packed words, hold each bias for rpt_cfg conv_ends
module bias_stream_pp
  import bias_stream_pp_pkg::*;
#(
  parameter int BIAS_W = bias_stream_pp_pkg::BIAS_W,
  parameter int LANES  = bias_stream_pp_pkg::LANES,
  parameter int NBUF   = 2,
  parameter int RPT_W  = 15,
  parameter int NUM_W  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [RPT_W-1:0]   rpt_cfg_i,
  input  logic [NUM_W-1:0]   num_bias_i,
  bias_stream_pp_if.master   bus,
  output logic               done_o,
  output logic               busy_o,
  output logic               err_underrun_o
);

  localparam int LANE_W = idx_w(LANES);
  localparam int WN_W   = NUM_W + 1;

  fill_state_e       fs_q;
  logic              src_rd_en_q;
  logic [NUM_W-1:0]  words_fetched_q;

  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [RPT_W-1:0]  rpt_q;
  logic [NUM_W-1:0]  num_q;
  logic [RPT_W-1:0]  rpt_cnt_q;
  logic [LANE_W-1:0] lane_idx_q;
  logic [NUM_W-1:0]  emitted_q;

  logic              wr_full;
  logic              rd_full;
  logic [BIAS_W-1:0] rd_lane;
  logic              bank_wr;
  logic              bank_free;
  logic              bias_valid;
  logic              accept;
  logic              last_rpt;
  logic              last_lane;
  logic              last_bias;
  logic [RPT_W-1:0]  rpt_last;
  logic [WN_W-1:0]   words_needed;
  logic              need_word;

  // Words per layer rounded up; one spare bit so num_bias near full scale cannot overflow.
  assign words_needed = ({1'b0, num_q} + WN_W'(LANES - 1)) / WN_W'(LANES);
  assign need_word    = {1'b0, words_fetched_q} < words_needed;

  assign bias_valid = busy_q && rd_full;
  assign accept     = bus.conv_end && bias_valid;
  assign rpt_last   = (rpt_q == '0) ? '0 : rpt_q - 1'b1;
  assign last_rpt   = (rpt_cnt_q == rpt_last);
  assign last_lane  = (lane_idx_q == LANE_W'(LANES - 1));
  assign last_bias  = ((emitted_q + 1'b1) == num_q);
  assign bank_wr    = (fs_q == FS_WAIT) && !start_i;
  assign bank_free  = accept && last_rpt && (last_lane || last_bias) && !start_i;

  bias_stream_pp_bank_rf #(
    .BIAS_W (BIAS_W),
    .LANES  (LANES),
    .NBUF   (NBUF),
    .LANE_W (LANE_W)
  ) u_bank_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start_i),
    .wr_en_i    (bank_wr),
    .wr_data_i  (bus.src_din),
    .free_i     (bank_free),
    .lane_idx_i (lane_idx_q),
    .wr_full_o  (wr_full),
    .rd_full_o  (rd_full),
    .rd_lane_o  (rd_lane)
  );

  // Fill FSM: one outstanding read; start drops any read in flight so its data is never captured.
  always_ff @(posedge clk) begin
    if (!rst_n || start_i) begin
      fs_q            <= FS_IDLE;
      src_rd_en_q     <= 1'b0;
      words_fetched_q <= '0;
    end else begin
      case (fs_q)
        FS_IDLE: begin
          src_rd_en_q <= 1'b0;
          if (busy_q && bus.src_avail && !wr_full && need_word) begin
            fs_q            <= FS_REQ;
            src_rd_en_q     <= 1'b1;
            words_fetched_q <= words_fetched_q + 1'b1;
          end
        end
        FS_REQ: begin
          fs_q        <= FS_WAIT;
          src_rd_en_q <= 1'b0;
        end
        FS_WAIT: begin
          fs_q        <= FS_IDLE;
          src_rd_en_q <= 1'b0;
        end
        default: begin
          fs_q        <= FS_IDLE;
          src_rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Emit side: repeat/lane/emitted counters, end-of-layer pulse and sticky underrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rpt_q      <= '0;
      num_q      <= '0;
      rpt_cnt_q  <= '0;
      lane_idx_q <= '0;
      emitted_q  <= '0;
    end else if (start_i) begin
      busy_q     <= (num_bias_i != '0);
      done_q     <= (num_bias_i == '0);
      err_q      <= 1'b0;
      rpt_q      <= rpt_cfg_i;
      num_q      <= num_bias_i;
      rpt_cnt_q  <= '0;
      lane_idx_q <= '0;
      emitted_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.conv_end && busy_q && !bias_valid) begin
        err_q <= 1'b1;
      end
      if (accept) begin
        if (last_rpt) begin
          rpt_cnt_q  <= '0;
          emitted_q  <= emitted_q + 1'b1;
          lane_idx_q <= (last_lane || last_bias) ? '0 : lane_idx_q + 1'b1;
          if (last_bias) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end else begin
          rpt_cnt_q <= rpt_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.src_rd_en  = src_rd_en_q;
  assign bus.bias_valid = bias_valid;
  assign bus.bias_data  = bias_valid ? rd_lane : '0;
  assign done_o         = done_q;
  assign busy_o         = busy_q;
  assign err_underrun_o = err_q;

endmodule

// File: tb/tb_bias_stream_pp.sv
// tb/tb_bias_stream_pp.sv - directed self-checking bench for bias_stream_pp
module tb_bias_stream_pp;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] rpt_cfg;
  logic [11:0] num_bias;
  logic        done;
  logic        busy;
  logic        err;

  int checks;
  int passed;

  logic [63:0] mem [0:3];
  int          rd_idx;

  bias_stream_pp_if #(.BIAS_W(16), .LANES(4)) ifc ();

  bias_stream_pp #(
    .BIAS_W (16),
    .LANES  (4),
    .NBUF   (2),
    .RPT_W  (15),
    .NUM_W  (12)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .rpt_cfg_i      (rpt_cfg),
    .num_bias_i     (num_bias),
    .bus            (ifc.master),
    .done_o         (done),
    .busy_o         (busy),
    .err_underrun_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bias BRAM model: data one cycle after the read strobe; start rewinds the read address.
  always @(posedge clk) begin
    if (start) begin
      rd_idx <= 0;
    end else if (ifc.src_rd_en) begin
      ifc.src_din <= mem[rd_idx[1:0]];
      rd_idx      <= rd_idx + 1;
    end
  end

  task automatic do_start(input logic [14:0] r, input logic [11:0] n);
    start    = 1'b1;
    rpt_cfg  = r;
    num_bias = n;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic consume_one(output logic [15:0] d, output logic v, output logic dn);
    int w;
    w = 0;
    while (ifc.bias_valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    d = ifc.bias_data;
    v = ifc.bias_valid;
    ifc.conv_end = 1'b1;
    @(negedge clk);
    ifc.conv_end = 1'b0;
    dn = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.src_rd_en !== 1'b0 || ifc.bias_valid !== 1'b0 || ifc.bias_data !== 16'h0 ||
        done !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_outputs got rd=%b v=%b d=%h done=%b busy=%b err=%b want all 0",
               ifc.src_rd_en, ifc.bias_valid, ifc.bias_data, done, busy, err);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_num();
    do_start(15'd2, 12'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_num_done got done=%b busy=%b want done=1 busy=0", done, busy);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ifc.src_rd_en !== 1'b0)
      $display("FAIL zero_num_pulse got done=%b rd=%b want 0 0", done, ifc.src_rd_en);
    else passed++;
  endtask

  task automatic test_single_word();
    logic [15:0] d;
    logic        v;
    logic        dn;
    mem[0] = 64'h0004_0003_0002_0001;
    ifc.src_avail = 1'b1;
    do_start(15'd3, 12'd4);
    for (int i = 0; i < 12; i++) begin
      consume_one(d, v, dn);
      checks++;
      if (v !== 1'b1 || d !== 16'(i / 3 + 1) || dn !== (i == 11))
        $display("FAIL t1_step%0d got v=%b d=%h done=%b want v=1 d=%h done=%b",
                 i, v, d, dn, 16'(i / 3 + 1), (i == 11));
      else passed++;
    end
    checks++;
    if (busy !== 1'b0 || ifc.bias_valid !== 1'b0)
      $display("FAIL t1_idle got busy=%b v=%b want 0 0", busy, ifc.bias_valid);
    else passed++;
  endtask

  task automatic test_partial_word();
    logic [15:0] d;
    logic        v;
    logic        dn;
    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;
    ifc.src_avail = 1'b1;
    do_start(15'd2, 12'd6);
    for (int i = 0; i < 12; i++) begin
      consume_one(d, v, dn);
      checks++;
      if (v !== 1'b1 || d !== 16'(i / 2 + 1) || dn !== (i == 11))
        $display("FAIL t2_step%0d got v=%b d=%h done=%b want v=1 d=%h done=%b",
                 i, v, d, dn, 16'(i / 2 + 1), (i == 11));
      else passed++;
    end
    checks++;
    if (rd_idx != 2 || ifc.bias_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL t2_reads got reads=%0d v=%b busy=%b want 2 0 0", rd_idx, ifc.bias_valid, busy);
    else passed++;
  endtask

  task automatic test_underrun();
    logic [15:0] d;
    logic        v;
    logic        dn;
    int          w;
    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;
    mem[2] = 64'h000c_000b_000a_0009;
    ifc.src_avail = 1'b1;
    do_start(15'd1, 12'd12);
    w = 0;
    while (ifc.bias_valid !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    ifc.src_avail = 1'b0;
    for (int i = 0; i < 4; i++) begin
      consume_one(d, v, dn);
      checks++;
      if (v !== 1'b1 || d !== 16'(i + 1) || dn !== 1'b0)
        $display("FAIL t3_pre%0d got v=%b d=%h done=%b want v=1 d=%h done=0", i, v, d, dn, 16'(i + 1));
      else passed++;
    end
    checks++;
    if (err !== 1'b0 || ifc.bias_valid !== 1'b0)
      $display("FAIL t3_drained got err=%b v=%b want 0 0", err, ifc.bias_valid);
    else passed++;
    ifc.conv_end = 1'b1;
    repeat (10) @(negedge clk);
    ifc.conv_end = 1'b0;
    checks++;
    if (err !== 1'b1 || ifc.bias_valid !== 1'b0 || ifc.bias_data !== 16'h0 || rd_idx != 1 || busy !== 1'b1)
      $display("FAIL t3_underrun got err=%b v=%b d=%h reads=%0d busy=%b want 1 0 0000 1 1",
               err, ifc.bias_valid, ifc.bias_data, rd_idx, busy);
    else passed++;
    ifc.src_avail = 1'b1;
    for (int i = 4; i < 12; i++) begin
      consume_one(d, v, dn);
      checks++;
      if (v !== 1'b1 || d !== 16'(i + 1) || dn !== (i == 11))
        $display("FAIL t3_post%0d got v=%b d=%h done=%b want v=1 d=%h done=%b",
                 i, v, d, dn, 16'(i + 1), (i == 11));
      else passed++;
    end
    checks++;
    if (err !== 1'b1)
      $display("FAIL t3_sticky got err=%b want 1", err);
    else passed++;
  endtask

  task automatic test_rpt_zero_wrap();
    logic [15:0] d;
    logic        v;
    logic        dn;
    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;
    mem[2] = 64'h000c_000b_000a_0009;
    ifc.src_avail = 1'b1;
    do_start(15'd0, 12'd12);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1)
      $display("FAIL t4_start got err=%b busy=%b want 0 1", err, busy);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      consume_one(d, v, dn);
      checks++;
      if (v !== 1'b1 || d !== 16'(i + 1) || dn !== (i == 11))
        $display("FAIL t4_step%0d got v=%b d=%h done=%b want v=1 d=%h done=%b",
                 i, v, d, dn, 16'(i + 1), (i == 11));
      else passed++;
    end
    checks++;
    if (rd_idx != 3)
      $display("FAIL t4_reads got %0d want 3", rd_idx);
    else passed++;
  endtask

  task automatic test_abort_wait();
    logic [15:0] d;
    logic        v;
    logic        dn;
    int          w;
    mem[0] = 64'h0004_0003_0002_0001;
    ifc.src_avail = 1'b1;
    do_start(15'd1, 12'd4);
    w = 0;
    while (ifc.src_rd_en !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (ifc.src_rd_en !== 1'b1)
      $display("FAIL t5_req got rd=%b want 1", ifc.src_rd_en);
    else passed++;
    @(negedge clk);
    mem[0] = 64'h00dd_00cc_00bb_00aa;
    do_start(15'd1, 12'd4);
    checks++;
    if (busy !== 1'b1 || ifc.bias_valid !== 1'b0)
      $display("FAIL t5_restart got busy=%b v=%b want 1 0", busy, ifc.bias_valid);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      consume_one(d, v, dn);
      checks++;
      if (v !== 1'b1 || d !== 16'(8'haa + 8'h11 * i) || dn !== (i == 3))
        $display("FAIL t5_step%0d got v=%b d=%h done=%b want v=1 d=%h done=%b",
                 i, v, d, dn, 16'(8'haa + 8'h11 * i), (i == 3));
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] d;
    logic        v;
    logic        dn;
    int          seen;
    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;
    ifc.src_avail = 1'b1;
    do_start(15'd2, 12'd8);
    for (int i = 0; i < 3; i++) begin
      consume_one(d, v, dn);
      checks++;
      if (v !== 1'b1 || d !== 16'(i / 2 + 1))
        $display("FAIL t6_pre%0d got v=%b d=%h want v=1 d=%h", i, v, d, 16'(i / 2 + 1));
      else passed++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (ifc.src_rd_en !== 1'b0 || ifc.bias_valid !== 1'b0 || ifc.bias_data !== 16'h0 ||
        done !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL t6_reset got rd=%b v=%b d=%h done=%b busy=%b err=%b want all 0",
               ifc.src_rd_en, ifc.bias_valid, ifc.bias_data, done, busy, err);
    else passed++;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifc.src_rd_en === 1'b1 || ifc.bias_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0)
      $display("FAIL t6_quiet got %0d active cycles want 0", seen);
    else passed++;
    do_start(15'd1, 12'd4);
    for (int i = 0; i < 4; i++) begin
      consume_one(d, v, dn);
      checks++;
      if (v !== 1'b1 || d !== 16'(i + 1) || dn !== (i == 3))
        $display("FAIL t6_post%0d got v=%b d=%h done=%b want v=1 d=%h done=%b",
                 i, v, d, dn, 16'(i + 1), (i == 3));
      else passed++;
    end
  endtask

  initial begin
    checks       = 0;
    passed       = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    rpt_cfg      = '0;
    num_bias     = '0;
    ifc.conv_end = 1'b0;
    ifc.src_avail = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    @(negedge clk);
    test_reset();
    test_zero_num();
    test_single_word();
    test_partial_word();
    test_underrun();
    test_rpt_zero_wrap();
    test_abort_wait();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached after %0d/%0d checks", passed, checks);
    $fatal(1);
  end

endmodule
